// File: rtl/nmr_cpmg_seq_gen.sv
// CPMG pulse-program sequencer: optional T1 inversion prefix, 90 pulse, then N x (180 pulse + acquisition).
// Define NMR_SEQ_T1_INV_EN to build the T1 inversion-recovery prefix (T1P/T1D states).
module nmr_cpmg_seq_gen #(
  parameter int PULSE_AND_DELAY_WIDTH  = 32,
  parameter int ECHO_PER_SCAN_WIDTH    = 32,
  parameter int SAMPLES_PER_ECHO_WIDTH = 32,
  parameter int ADC_INIT_DELAY_WIDTH   = 32,
  parameter int PHASE_WIDTH            = 2
) (
  input  logic                              PULSEPROG_CLK,
  input  logic                              RESET_N,
  input  logic                              START,
  input  logic                              ABORT,
  input  logic [PULSE_AND_DELAY_WIDTH-1:0]  T1_PULSE180,
  input  logic [PULSE_AND_DELAY_WIDTH-1:0]  T1_DELAY,
  input  logic [PULSE_AND_DELAY_WIDTH-1:0]  PULSE90,
  input  logic [PULSE_AND_DELAY_WIDTH-1:0]  DELAY_NO_ACQ,
  input  logic [PULSE_AND_DELAY_WIDTH-1:0]  PULSE180,
  input  logic [PULSE_AND_DELAY_WIDTH-1:0]  DELAY_WITH_ACQ,
  input  logic [ECHO_PER_SCAN_WIDTH-1:0]    ECHO_PER_SCAN,
  input  logic [SAMPLES_PER_ECHO_WIDTH-1:0] SAMPLES_PER_ECHO,
  input  logic [ADC_INIT_DELAY_WIDTH-1:0]   ADC_INIT_DELAY,
  input  logic [ADC_INIT_DELAY_WIDTH-1:0]   RX_DELAY,
  input  logic [PHASE_WIDTH-1:0]            PHASE90,
  input  logic [PHASE_WIDTH-1:0]            PHASE180_A,
  input  logic [PHASE_WIDTH-1:0]            PHASE180_B,
  output logic                              FSMSTAT,
  output logic                              RF_GATE,
  output logic [PHASE_WIDTH-1:0]            RF_PHASE,
  output logic                              EN_RX,
  output logic                              ACQ_WND,
  output logic [ECHO_PER_SCAN_WIDTH-1:0]    ECHO_CNT,
  output logic                              ECHO_DONE,
  output logic                              SEQ_DONE
);
  localparam int PDW = PULSE_AND_DELAY_WIDTH;
  localparam int EW  = ECHO_PER_SCAN_WIDTH;
  localparam int SW  = SAMPLES_PER_ECHO_WIDTH;
  localparam int AW  = ADC_INIT_DELAY_WIDTH;
  localparam int MW  = (PDW > AW) ? PDW : AW;
  localparam int CW  = ((MW > SW) ? MW : SW) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_T1P, S_T1D, S_P90, S_D90, S_P180, S_DACQ, S_FIN
  } state_t;

  state_t         state;
  logic [PDW-1:0] tcnt;
  logic [PDW-1:0] ocnt;

  logic [PDW-1:0]         dna_r, p180_r, dwa_r;
  logic [EW-1:0]          eps_r;
  logic [SW-1:0]          spe_r;
  logic [AW-1:0]          adc_r, rx_r;
  logic [PHASE_WIDTH-1:0] pha_r, phb_r;
`ifdef NMR_SEQ_T1_INV_EN
  logic [PDW-1:0]         t1d_r, p90_r;
  logic [PHASE_WIDTH-1:0] ph90_r;
`else
  logic unused_t1;
  assign unused_t1 = ^{T1_PULSE180, T1_DELAY};
`endif

  logic          start_ok;
  logic [CW-1:0] acq_end;

  assign start_ok = (state == S_IDLE) && START && !ABORT;
  // one bit wider than any operand so the window end never wraps
  assign acq_end  = CW'(adc_r) + CW'(spe_r);

  function automatic logic [PDW-1:0] dur_m1(input logic [PDW-1:0] n);
    return (n == '0) ? '0 : n - PDW'(1);
  endfunction

  function automatic logic rx_on(input logic [PDW-1:0] c, input logic [AW-1:0] rx);
    return CW'(c) >= CW'(rx);
  endfunction

  function automatic logic acq_on(input logic [PDW-1:0] c, input logic [AW-1:0] adc,
                                  input logic [CW-1:0] lim);
    return (CW'(c) >= CW'(adc)) && (CW'(c) < lim);
  endfunction

  // Parameter snapshot taken on the accepted START; inputs are free to change afterwards.
  always_ff @(posedge PULSEPROG_CLK) begin
    if (start_ok) begin
      dna_r  <= DELAY_NO_ACQ;
      p180_r <= PULSE180;
      dwa_r  <= DELAY_WITH_ACQ;
      eps_r  <= ECHO_PER_SCAN;
      spe_r  <= SAMPLES_PER_ECHO;
      adc_r  <= ADC_INIT_DELAY;
      rx_r   <= RX_DELAY;
      pha_r  <= PHASE180_A;
      phb_r  <= PHASE180_B;
`ifdef NMR_SEQ_T1_INV_EN
      t1d_r  <= T1_DELAY;
      p90_r  <= PULSE90;
      ph90_r <= PHASE90;
`endif
    end
  end

  // Sequencer: outputs are registered for the state being entered, so they line up with it.
  always_ff @(posedge PULSEPROG_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= S_IDLE;
      tcnt      <= '0;
      ocnt      <= '0;
      FSMSTAT   <= 1'b0;
      RF_GATE   <= 1'b0;
      RF_PHASE  <= '0;
      EN_RX     <= 1'b0;
      ACQ_WND   <= 1'b0;
      ECHO_CNT  <= '0;
      ECHO_DONE <= 1'b0;
      SEQ_DONE  <= 1'b0;
    end else if (ABORT) begin
      state     <= S_IDLE;
      FSMSTAT   <= 1'b0;
      RF_GATE   <= 1'b0;
      RF_PHASE  <= '0;
      EN_RX     <= 1'b0;
      ACQ_WND   <= 1'b0;
      ECHO_DONE <= 1'b0;
      SEQ_DONE  <= 1'b0;
    end else begin
      ECHO_DONE <= 1'b0;
      SEQ_DONE  <= 1'b0;
      if (tcnt != '0) tcnt <= tcnt - PDW'(1);
      case (state)
        S_IDLE: begin
          RF_PHASE <= '0;
          if (START) begin
            ECHO_CNT <= '0;
            FSMSTAT  <= 1'b1;
            RF_GATE  <= 1'b1;
`ifdef NMR_SEQ_T1_INV_EN
            if (T1_PULSE180 != '0) begin
              state    <= S_T1P;
              tcnt     <= dur_m1(T1_PULSE180);
              RF_PHASE <= PHASE180_A;
            end else begin
              state    <= S_P90;
              tcnt     <= dur_m1(PULSE90);
              RF_PHASE <= PHASE90;
            end
`else
            state    <= S_P90;
            tcnt     <= dur_m1(PULSE90);
            RF_PHASE <= PHASE90;
`endif
          end
        end
`ifdef NMR_SEQ_T1_INV_EN
        S_T1P: if (tcnt == '0) begin
          if (t1d_r != '0) begin
            state   <= S_T1D;
            tcnt    <= dur_m1(t1d_r);
            RF_GATE <= 1'b0;
          end else begin
            state    <= S_P90;
            tcnt     <= dur_m1(p90_r);
            RF_PHASE <= ph90_r;
          end
        end
        S_T1D: if (tcnt == '0) begin
          state    <= S_P90;
          tcnt     <= dur_m1(p90_r);
          RF_GATE  <= 1'b1;
          RF_PHASE <= ph90_r;
        end
`endif
        S_P90: if (tcnt == '0) begin
          state   <= S_D90;
          tcnt    <= dur_m1(dna_r);
          RF_GATE <= 1'b0;
        end
        S_D90: if (tcnt == '0) begin
          if (eps_r == '0) begin
            state    <= S_FIN;
            FSMSTAT  <= 1'b0;
            SEQ_DONE <= 1'b1;
          end else begin
            state    <= S_P180;
            tcnt     <= dur_m1(p180_r);
            RF_GATE  <= 1'b1;
            RF_PHASE <= pha_r;
          end
        end
        S_P180: if (tcnt == '0) begin
          state   <= S_DACQ;
          tcnt    <= dur_m1(dwa_r);
          ocnt    <= '0;
          RF_GATE <= 1'b0;
          EN_RX   <= rx_on('0, rx_r);
          ACQ_WND <= acq_on('0, adc_r, acq_end);
        end
        S_DACQ: begin
          if (tcnt != '0) begin
            ocnt    <= ocnt + PDW'(1);
            EN_RX   <= rx_on(ocnt + PDW'(1), rx_r);
            ACQ_WND <= acq_on(ocnt + PDW'(1), adc_r, acq_end);
          end else begin
            EN_RX     <= 1'b0;
            ACQ_WND   <= 1'b0;
            ECHO_CNT  <= ECHO_CNT + EW'(1);
            ECHO_DONE <= 1'b1;
            if (ECHO_CNT == eps_r - EW'(1)) begin
              state    <= S_FIN;
              FSMSTAT  <= 1'b0;
              SEQ_DONE <= 1'b1;
            end else begin
              // ECHO_CNT is the index of the echo just finished; the next one has opposite parity
              state    <= S_P180;
              tcnt     <= dur_m1(p180_r);
              RF_GATE  <= 1'b1;
              RF_PHASE <= ECHO_CNT[0] ? pha_r : phb_r;
            end
          end
        end
        S_FIN: begin
          state    <= S_IDLE;
          RF_PHASE <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
